// File: rtl/osc_nco.sv
// Phase-accumulator oscillator: saw/square/triangle/silence samples at a fixed tick rate,
// handed to the DAC stage over valid/ready with overrun flagging.
module osc_nco #(
   parameter int unsigned CLK_DIV = 1042,
   parameter int unsigned PHASE_W = 24
) (
   input  logic               IN_CLOCK,
   input  logic               IN_RESET,
   input  logic               IN_ENABLE,
   input  logic [PHASE_W-1:0] IN_FREQ_WORD,
   input  logic [1:0]         IN_WAVE,
   input  logic               IN_DAC_READY,
   output logic [11:0]        OUT_BITS,
   output logic               OUT_VALID,
   output logic               OUT_OVERRUN
);

   localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned    SAMPLE_W = 12;
   localparam int unsigned    TRI_W    = SAMPLE_W - 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [1:0] WAVE_SAW      = 2'b00;
   localparam logic [1:0] WAVE_SQUARE   = 2'b01;
   localparam logic [1:0] WAVE_TRIANGLE = 2'b10;

   localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_SHAPE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DIV_W-1:0]    r_div;
   logic [DIV_W-1:0]    w_div_nxt;
   logic                w_tick;
   logic                w_shape;
   logic                w_xfer;
   logic [PHASE_W-1:0]  r_phase;
   logic [1:0]          r_wave;
   logic [TRI_W-1:0]    w_tri;
   logic [SAMPLE_W-1:0] w_sample;

   // State and divider registers
   always_ff @(posedge IN_CLOCK) begin
      if (IN_RESET) begin
         r_state <= S_IDLE;
         r_div   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
      end
   end

   // Next state, divider and tick; the divider keeps running through SHAPE so ticks stay CLK_DIV apart
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = '0;
      w_tick      = 1'b0;
      w_shape     = (r_state == S_SHAPE);

      if (IN_ENABLE) begin
         w_tick    = (r_div == DIV_LAST);
         w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            if (IN_ENABLE) w_state_nxt = S_COUNT;
         end
         S_COUNT: begin
            if (!IN_ENABLE)  w_state_nxt = S_IDLE;
            else if (w_tick) w_state_nxt = S_SHAPE;
         end
         S_SHAPE: begin
            w_state_nxt = IN_ENABLE ? S_COUNT : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Waveform shaping from the freshly updated phase
   always_comb begin
      w_tri = r_phase[PHASE_W-2 -: TRI_W];
      case (r_wave)
         WAVE_SAW:      w_sample = r_phase[PHASE_W-1 -: SAMPLE_W];
         WAVE_SQUARE:   w_sample = {SAMPLE_W{r_phase[PHASE_W-1]}};
         WAVE_TRIANGLE: w_sample = r_phase[PHASE_W-1] ? ~{w_tri, 1'b0} : {w_tri, 1'b0};
         default:       w_sample = MIDSCALE;
      endcase
   end

   assign w_xfer = OUT_VALID & IN_DAC_READY;

   // Phase accumulator and output handshake register
   always_ff @(posedge IN_CLOCK) begin
      if (IN_RESET) begin
         r_phase     <= '0;
         r_wave      <= WAVE_SAW;
         OUT_BITS    <= MIDSCALE;
         OUT_VALID   <= 1'b0;
         OUT_OVERRUN <= 1'b0;
      end else begin
         OUT_OVERRUN <= 1'b0;
         if (w_tick) begin
            r_phase <= r_phase + IN_FREQ_WORD;
            r_wave  <= IN_WAVE;
         end
         if (w_shape) begin
            if (!OUT_VALID || w_xfer) begin
               OUT_BITS  <= w_sample;
               OUT_VALID <= 1'b1;
            end else begin
               OUT_OVERRUN <= 1'b1;
            end
         end else if (w_xfer) begin
            OUT_VALID <= 1'b0;
         end
      end
   end

endmodule

// File: doc/osc_nco.md
# osc_nco

Phase-accumulator oscillator that produces 12-bit audio samples at a fixed sample rate and hands them to the SPI DAC stage over a valid/ready handshake. Sits directly upstream of the DAC driver: its `OUT_BITS` feeds the DAC's `IN_BITS`. Generates saw, square and triangle waveforms, plus a midscale silence code, from a programmable frequency word. Flags dropped samples when the DAC cannot keep up.

## Interface
- `CLK_DIV`, default 1042: system clocks per sample tick (50 MHz / 1042 ≈ 48 kHz); ≥ 3.
- `PHASE_W`, default 24: phase accumulator width.
- `IN_CLOCK`  in  1: system clock. One clock domain.
- `IN_RESET`  in  1: reset, synchronous and active-high.
- `IN_ENABLE`  in  1: run oscillator; low freezes phase and clears divider.
- `IN_FREQ_WORD`  in  PHASE_W: phase increment per sample tick.
- `IN_WAVE`  in  2: waveform select. 00 saw, 01 square, 10 triangle, 11 silence.
- `IN_DAC_READY`  in  1: DAC accepts `OUT_BITS` this cycle.
- `OUT_BITS`  out  12: current sample.
- `OUT_VALID`  out  1: `OUT_BITS` holds an unaccepted sample.
- `OUT_OVERRUN`  out  1: one-cycle pulse when a new sample is dropped.

## Operation
- **Reset values:** phase 0, divider 0, `OUT_BITS` = 12'h800, `OUT_VALID` = 0, `OUT_OVERRUN` = 0. Reset overrides all other activity, including a pending handshake; that sample is discarded.
- **Divider**
  - Counts 0..CLK_DIV-1 while `IN_ENABLE` is high.
  - Tick = enabled AND count == CLK_DIV-1; the count wraps to 0 on the tick.
  - `IN_ENABLE` low: divider forced to 0, no ticks.
- **Phase**
  - On a tick, phase <= phase + `IN_FREQ_WORD`, modulo 2^PHASE_W, with silent wrap.
  - `IN_FREQ_WORD` and `IN_WAVE` are sampled only in the tick cycle and registered for the shaping stage.
- **Shaping** (from the updated phase; P = phase, M = P[PHASE_W-1]):
  - saw: P[PHASE_W-1 -: 12].
  - square: M ? 12'hFFF : 12'h000.
  - triangle: t = P[PHASE_W-2 -: 11]; M ? ~{t,1'b0} : {t,1'b0}.
  - silence: 12'h800. Phase still advances.
- **Output register / handshake** (load evaluated in shaping cycle S = tick+1):
  - Transfer occurs when `OUT_VALID` and `IN_DAC_READY` are both high in the same cycle.
  - `OUT_BITS` stays stable while `OUT_VALID` is high and no transfer has occurred.
  - Shaping cycle, `OUT_VALID` low: load the new sample and set `OUT_VALID`.
  - Shaping cycle with a simultaneous transfer: load the new sample; `OUT_VALID` stays high.
  - Shaping cycle, `OUT_VALID` high and `IN_DAC_READY` low: new sample dropped; old sample and `OUT_VALID` kept; `OUT_OVERRUN` = 1 for one cycle.
  - Transfer with no load: `OUT_VALID` <= 0.
- **`IN_ENABLE` deasserted:**
  - A sample already valid still completes its handshake normally.
  - A tick that occurred in the cycle before deassertion still reaches its shaping stage and loads.
- **State machine:** IDLE (disabled, divider 0) -> COUNT (enabled, counting) -> SHAPE (one cycle after tick) -> COUNT.
  - SHAPE returns to IDLE if `IN_ENABLE` is low.
  - Requiring CLK_DIV ≥ 3 ensures that SHAPE never coincides with the next tick.

## Timing
- Tick in cycle T; phase register is updated at the end of T.
- Shaping stage in T+1; `OUT_BITS`/`OUT_VALID` are visible from T+2. Tick-to-valid latency is 2 cycles.
- `OUT_OVERRUN` is visible in T+2 for exactly one cycle.
- With `IN_DAC_READY` tied high, each sample is valid for exactly one cycle. Samples are spaced exactly CLK_DIV cycles apart.
- First tick after `IN_ENABLE` rises occurs CLK_DIV cycles later.
- Throughput limit: the DAC must accept within CLK_DIV-1 cycles of `OUT_VALID` rising, or the next sample overruns.

## Test plan
All scenarios use CLK_DIV = 4 and PHASE_W = 24.
- **Reset:** hold `IN_RESET` 3 cycles with `IN_ENABLE` = 1 -> `OUT_BITS` = 12'h800, `OUT_VALID` = 0, `OUT_OVERRUN` = 0; first `OUT_VALID` appears 4+2 cycles after release.
- **Saw:** `IN_FREQ_WORD` = 24'h100000, `IN_WAVE` = 00, ready high -> `OUT_BITS` = 0x100, 0x200, ..., 0xF00, 0x000, 0x100 at 4-cycle spacing, one-cycle `OUT_VALID` pulses.
- **Square:** `IN_FREQ_WORD` = 24'h400000, `IN_WAVE` = 01 -> 0x000, 0xFFF, 0xFFF, 0x000 repeating.
- **Triangle:** `IN_FREQ_WORD` = 24'h200000, `IN_WAVE` = 10 -> 0x400, 0x800, 0xC00, 0xFFF, 0xBFF, 0x7FF, 0x3FF, 0x000?
  - Check: for phase 0xE00000, t = 0x600, so ~0xC00 = 0x3FF. For phase 0x000000, output is 0x000.
- **Overrun:** ready low across two ticks -> `OUT_BITS` holds first sample, `OUT_OVERRUN` pulses once in T+2 of the second tick; raise ready -> transfer, `OUT_VALID` drops next cycle, next sample follows the phase sequence without gap.
- **Disable and reset mid-run:**
  - Drop `IN_ENABLE` with a sample pending, ready low -> sample held; raise ready -> accepted; no further `OUT_VALID`, phase frozen.
  - Assert `IN_RESET` while `OUT_VALID` is high -> `OUT_VALID` = 0 next cycle.
